icache_l1: RTL
==============

Name: icache_l1

Overview:
- Direct-mapped, read-only L1 instruction cache that sits directly upstream of the compute-unit fetch stage.
- Serves one 64-bit aligned bundle per request over the fetch req/resp handshake: 1-cycle hit latency; misses refill a full line from the memory port.
- Supports fetch-redirect kill, so no stale response is delivered, and full invalidation for fence.i.

Parameters:
NUM_LINES, 64, number of lines; power of two, >=2
LINE_BYTES, 32, line size; power of two, multiple of 8, >=16
Derived: BEATS=LINE_BYTES/8; OFF_W=log2(LINE_BYTES); IDX_W=log2(NUM_LINES); TAG_W=32-OFF_W-IDX_W

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  fetch request
req_addr  in  32  byte address; bits [2:0] ignored
req_ready  out  1  request accepted this cycle when req_valid&&req_ready
resp_valid  out  1  one-cycle pulse, data valid
resp_data  out  64  bundle at req_addr[31:3]
kill  in  1  fetch redirect: drop outstanding/current response
inval  in  1  pulse: invalidate all lines
mem_req_valid  out  1  line refill request
mem_req_addr  out  32  line-aligned address
mem_req_ready  in  1  memory accepts request
mem_resp_valid  in  1  refill beat valid
mem_resp_data  in  64  refill beat, beat 0 = line base, ascending
mem_resp_last  in  1  final beat marker
hit_count  out  32  accepted requests that hit; wraps
miss_count  out  32  accepted requests that missed; wraps

Behaviour:
- Reset (async, any state): state=IDLE; all valid bits=0; resp_valid=0; resp_data=0; mem_req_valid=0; mem_req_addr=0; counters=0; beat counter=0; kill_flag=0; inval_seen=0. Tag/data arrays are not reset.
- req_ready = (state==IDLE) && !kill && !inval, combinational.
- Address split: offset [OFF_W-1:0]; word select [OFF_W-1:3]; index [OFF_W+IDX_W-1:OFF_W]; tag [31:OFF_W+IDX_W].
- Hit, checked at accept: valid[idx] && tag[idx]==req tag.
  - Next cycle: resp_valid=1, resp_data=word.
  - hit_count+1.
  - State stays IDLE; back-to-back accepts allowed.
- Miss, at accept:
  - Latch address; miss_count+1; go to MREQ.
  - MREQ: mem_req_valid=1, mem_req_addr = line base. Hold both until mem_req_ready; then go to REFILL.
  - REFILL: each mem_resp_valid writes beat[cnt] to the data array and increments cnt.
  - On cnt==BEATS-1: write the tag; set valid[idx]=!inval_seen; go to RESP.
  - mem_resp_last is assertion-checked to coincide with cnt==BEATS-1; the beat counter governs.
  - RESP: resp_valid = !kill_flag && !kill, resp_data = requested word from the array; go to IDLE; clear kill_flag and inval_seen.
- Kill:
  - kill in any cycle forces resp_valid=0 that cycle.
  - kill during MREQ/REFILL sets kill_flag. Refill still completes and the line is still filled, but no response is delivered.
  - kill on a cycle with req_valid: no accept.
- Inval:
  - The cycle inval is high: all valid bits clear at the next edge.
  - If in MREQ/REFILL/RESP, inval_seen=1 so the refilled line is not validated. The response is still delivered if not killed.
  - inval and hit-accept in the same cycle cannot occur, because req_ready=0.
- Counters wrap at 2^32 with no saturation.
- Memory port: one outstanding refill only. mem_resp_valid outside REFILL is ignored; this is an assertion error.

Decomposition:
- Shared package icache_pkg: state enum {IDLE, MREQ, REFILL, RESP}, parameter defaults, and address-field extraction functions (idx/tag/word).
- One sub-module icache_array: tag+valid flops, data register array, combinational read port, beat write port, bulk valid clear.
- FSM and counters stay in icache_l1.

Test Plan:
- Cold miss at req_addr 0x0000_0000, memory beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> mem_req_addr=0x0; after last beat, one resp_valid with 0x1111_1111_1111_1111; miss_count=1.
- Then req 0x0000_0008 -> resp_valid exactly 1 cycle after accept, data 0x2222_2222_2222_2222; hit_count=1; no mem_req_valid.
- Req 0x0000_0800 (same index 0, new tag) -> miss, refill, response from new line; then re-req 0x0 -> miss again (evicted).
- Miss at 0x40, kill asserted during beat 2 -> refill completes, resp_valid never asserted; next req 0x48 hits.
- Warm lines 0x0 and 0x20, pulse inval -> req 0x0 and 0x20 both miss. Inval during refill of 0x60 -> response delivered, next req 0x60 misses.
- rst asserted mid-REFILL -> all outputs at reset values immediately; next req 0x0 misses and refills cleanly.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped L1 instruction cache.
package icache_pkg;

  localparam int NUM_LINES_DEF  = 64;
  localparam int LINE_BYTES_DEF = 32;

  typedef enum logic [1:0] {IDLE, MREQ, REFILL, RESP} state_t;

  function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int off_w, input int idx_w);
    return (addr >> off_w) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int off_w, input int idx_w);
    return addr >> (off_w + idx_w);
  endfunction

  // 64-bit bundle index inside a line
  function automatic logic [31:0] addr_word(input logic [31:0] addr, input int off_w);
    return (addr >> 3) & ((32'd1 << (off_w - 3)) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: combinational lookup port, single-beat write port, bulk valid clear.
module icache_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  localparam int OFF_W = $clog2(LINE_BYTES),
  localparam int IDX_W = $clog2(NUM_LINES),
  localparam int WRD_W = OFF_W - 3,
  localparam int TAG_W = 32 - OFF_W - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic [WRD_W-1:0] rd_word,
  output logic             rd_hit,
  output logic [63:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WRD_W-1:0] wr_word,
  input  logic [63:0]      wr_data,
  input  logic             tag_wr,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid,
  input  logic             clr
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [63:0]          data_mem [NUM_LINES * (LINE_BYTES / 8)];

  assign rd_data = data_mem[{rd_idx, rd_word}];
  assign rd_hit  = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);

  always_ff @(posedge clk) begin
    if (wr_en) data_mem[{wr_idx, wr_word}] <= wr_data;
    if (tag_wr) tag_mem[wr_idx] <= wr_tag;
  end

  // A bulk clear outranks a same-cycle line validation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (clr) begin
      valid <= '0;
    end else if (tag_wr) begin
      valid[wr_idx] <= wr_valid;
    end
  end

endmodule

// File: rtl/icache_l1.sv
// Direct-mapped read-only L1 instruction cache: 1-cycle hits, blocking line refill, kill and fence.i invalidate.
module icache_l1
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int LINE_BYTES = LINE_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [63:0] resp_data,
  input  logic        kill,
  input  logic        inval,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  input  logic        mem_resp_last,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int BEATS = LINE_BYTES / 8;
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int WRD_W = OFF_W - 3;
  localparam int TAG_W = 32 - OFF_W - IDX_W;

  state_t           state, state_nxt;
  logic [31:0]      addr_q;
  logic [WRD_W-1:0] cnt;
  logic             kill_flag;
  logic             inval_seen;
  logic             resp_valid_q;
  logic [31:0]      rd_addr;
  logic             hit;
  logic [63:0]      rd_data;
  logic             accept;
  logic             beat_we;
  logic             last_beat;

  assign req_ready  = (state == IDLE) && !kill && !inval;
  assign accept     = req_valid && req_ready;
  assign resp_valid = resp_valid_q && !kill;
  assign beat_we    = (state == REFILL) && mem_resp_valid;
  assign last_beat  = beat_we && (cnt == WRD_W'(BEATS - 1));
  // Lookup uses the live request while idle, the latched miss address otherwise
  assign rd_addr    = (state == IDLE) ? req_addr : addr_q;

  icache_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_BYTES(LINE_BYTES)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (IDX_W'(addr_idx(rd_addr, OFF_W, IDX_W))),
    .rd_tag  (TAG_W'(addr_tag(rd_addr, OFF_W, IDX_W))),
    .rd_word (WRD_W'(addr_word(rd_addr, OFF_W))),
    .rd_hit  (hit),
    .rd_data (rd_data),
    .wr_en   (beat_we),
    .wr_idx  (IDX_W'(addr_idx(addr_q, OFF_W, IDX_W))),
    .wr_word (cnt),
    .wr_data (mem_resp_data),
    .tag_wr  (last_beat),
    .wr_tag  (TAG_W'(addr_tag(addr_q, OFF_W, IDX_W))),
    .wr_valid(!inval_seen),
    .clr     (inval)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !hit) state_nxt = MREQ;
      MREQ:    if (mem_req_ready) state_nxt = REFILL;
      REFILL:  if (last_beat) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && !hit) addr_q <= req_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q  <= 1'b0;
      resp_data     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      cnt           <= '0;
      kill_flag     <= 1'b0;
      inval_seen    <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (accept && hit) begin
        resp_valid_q <= 1'b1;
        resp_data    <= rd_data;
        hit_count    <= hit_count + 32'd1;
      end
      if (accept && !hit) begin
        miss_count    <= miss_count + 32'd1;
        mem_req_valid <= 1'b1;
        mem_req_addr  <= {req_addr[31:OFF_W], OFF_W'(0)};
      end
      if ((state == MREQ) && mem_req_ready) mem_req_valid <= 1'b0;
      if (beat_we) cnt <= last_beat ? '0 : cnt + 1'b1;
      if (((state == MREQ) || (state == REFILL)) && kill) kill_flag <= 1'b1;
      if ((state != IDLE) && inval) inval_seen <= 1'b1;
      // Deliver the refilled word unless a redirect happened since the miss
      if (state == RESP) begin
        resp_valid_q <= !kill_flag && !kill;
        resp_data    <= rd_data;
        kill_flag    <= 1'b0;
        inval_seen   <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  a_last_beat: assert property (@(posedge clk) disable iff (rst)
    beat_we |-> (mem_resp_last == last_beat))
    else $error("mem_resp_last does not line up with the final refill beat");

  a_stray_resp: assert property (@(posedge clk) disable iff (rst)
    mem_resp_valid |-> (state == REFILL))
    else $error("mem_resp_valid outside REFILL");
`endif

endmodule
